// File: rtl/eth_mbox_pkg.sv
// Shared definitions for the Ethernet control mailbox to Avalon-MM bridge:
// mailbox command bit positions, FSM state type and the timeout read pattern.
package eth_mbox_pkg;

  localparam int MBOX_WR_BIT = 16;
  localparam int MBOX_RD_BIT = 17;

  localparam logic [31:0] MBOX_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT,
    DISARM
  } t_mbox_state;

endpackage

// File: rtl/eth_mbox_avmm_bridge.sv
// Turns one armed mailbox command into exactly one Avalon-MM read or write,
// with a bus timeout and re-arm on command release. All outputs are registered.
module eth_mbox_avmm_bridge
  import eth_mbox_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       eth_ctrl_addr,
  input  logic [DATA_W-1:0] eth_wr_data,
  output logic [DATA_W-1:0] eth_rd_data,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              cmd_err,
  output logic [ADDR_W-1:0] avmm_address,
  output logic              avmm_read,
  output logic              avmm_write,
  output logic [DATA_W-1:0] avmm_writedata,
  input  logic [DATA_W-1:0] avmm_readdata,
  input  logic              avmm_readdatavalid,
  input  logic              avmm_waitrequest
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  t_mbox_state       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              cmd_err_q, cmd_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [1:0] cmd;
  logic       expired;
  logic       unused_ctrl_bits;

  assign cmd              = {eth_ctrl_addr[MBOX_RD_BIT], eth_ctrl_addr[MBOX_WR_BIT]};
  assign expired          = (cnt_q == CNT_LAST);
  assign unused_ctrl_bits = ^eth_ctrl_addr;

  // NOTE: every signal assigned below gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_data_d     = rd_data_q;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;
    cmd_err_d     = cmd_err_q;
    addr_d        = addr_q;
    read_d        = read_q;
    write_d       = write_q;
    wdata_d       = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (cmd != 2'b00) begin
          done_d        = 1'b0;
          timeout_err_d = 1'b0;
          cmd_err_d     = 1'b0;
          cnt_d         = '0;
        end
        unique case (cmd)
          2'b01: begin
            addr_d  = eth_ctrl_addr[ADDR_W-1:0];
            wdata_d = eth_wr_data;
            write_d = 1'b1;
            state_d = WR;
          end
          2'b10: begin
            addr_d  = eth_ctrl_addr[ADDR_W-1:0];
            read_d  = 1'b1;
            state_d = RD;
          end
          2'b11: begin
            cmd_err_d = 1'b1;
            done_d    = 1'b1;
            state_d   = DISARM;
          end
          default: ;
        endcase
      end

      // Completion is tested before expiry so a same-cycle completion wins.
      WR: begin
        if (!avmm_waitrequest || expired) begin
          write_d       = 1'b0;
          done_d        = 1'b1;
          timeout_err_d = avmm_waitrequest;
          state_d       = DISARM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RD: begin
        if (!avmm_waitrequest) begin
          read_d  = 1'b0;
          state_d = RD_WAIT;
          // Saturate so a late address phase leaves one cycle for the data.
          if (!expired) cnt_d = cnt_q + 1'b1;
        end else if (expired) begin
          read_d        = 1'b0;
          done_d        = 1'b1;
          timeout_err_d = 1'b1;
          rd_data_d     = DATA_W'(MBOX_TIMEOUT_DATA);
          state_d       = DISARM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RD_WAIT: begin
        if (avmm_readdatavalid) begin
          rd_data_d = avmm_readdata;
          done_d    = 1'b1;
          state_d   = DISARM;
        end else if (expired) begin
          done_d        = 1'b1;
          timeout_err_d = 1'b1;
          rd_data_d     = DATA_W'(MBOX_TIMEOUT_DATA);
          state_d       = DISARM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DISARM: begin
        if (cmd == 2'b00) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WR) || (state_d == RD) || (state_d == RD_WAIT);
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rd_data_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      cmd_err_q     <= 1'b0;
      addr_q        <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_data_q     <= rd_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      cmd_err_q     <= cmd_err_d;
      addr_q        <= addr_d;
      read_q        <= read_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
    end
  end

  assign eth_rd_data    = rd_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout_err    = timeout_err_q;
  assign cmd_err        = cmd_err_q;
  assign avmm_address   = addr_q;
  assign avmm_read      = read_q;
  assign avmm_write     = write_q;
  assign avmm_writedata = wdata_q;

endmodule

// File: tb/tb_eth_mbox_avmm_bridge.sv
// Bench for the mailbox bridge: directed scenarios with literal expectations,
// then random commands and slave behaviour checked every cycle against a model.
module tb_eth_mbox_avmm_bridge;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       eth_ctrl_addr;
  logic [DATA_W-1:0] eth_wr_data;
  logic [DATA_W-1:0] eth_rd_data;
  logic              busy, done, timeout_err, cmd_err;
  logic [ADDR_W-1:0] avmm_address;
  logic              avmm_read, avmm_write;
  logic [DATA_W-1:0] avmm_writedata;
  logic [DATA_W-1:0] avmm_readdata;
  logic              avmm_readdatavalid;
  logic              avmm_waitrequest;

  eth_mbox_avmm_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .eth_ctrl_addr(eth_ctrl_addr), .eth_wr_data(eth_wr_data),
    .eth_rd_data(eth_rd_data), .busy(busy), .done(done),
    .timeout_err(timeout_err), .cmd_err(cmd_err),
    .avmm_address(avmm_address), .avmm_read(avmm_read),
    .avmm_write(avmm_write), .avmm_writedata(avmm_writedata),
    .avmm_readdata(avmm_readdata), .avmm_readdatavalid(avmm_readdatavalid),
    .avmm_waitrequest(avmm_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy, m_release, m_is_rd, m_addr_done;
  int          m_age;
  logic [31:0] e_rd_data, e_wdata;
  logic [15:0] e_addr;
  logic        e_done, e_terr, e_cerr, e_read, e_write;

  int wr_issues = 0, wr_hi = 0, rd_hi = 0;
  logic prev_wr = 1'b0;

  task automatic finish_txn(input bit timed_out);
    m_busy    = 0;
    m_release = 1;
    e_done    = 1;
    e_terr    = timed_out;
    e_read    = 0;
    e_write   = 0;
    if (timed_out && m_is_rd) e_rd_data = 32'hDEAD_BEEF;
  endtask

  task automatic model_step();
    logic [1:0] c;
    c = {eth_ctrl_addr[17], eth_ctrl_addr[16]};
    if (reset) begin
      m_busy = 0; m_release = 0; m_age = 0;
      e_rd_data = '0; e_wdata = '0; e_addr = '0;
      e_done = 0; e_terr = 0; e_cerr = 0; e_read = 0; e_write = 0;
    end else if (m_busy) begin
      m_age++;
      if (!m_is_rd) begin
        if (!avmm_waitrequest) finish_txn(0);
        else if (m_age >= TMO) finish_txn(1);
      end else if (!m_addr_done) begin
        if (!avmm_waitrequest) begin m_addr_done = 1; e_read = 0; end
        else if (m_age >= TMO) finish_txn(1);
      end else begin
        if (avmm_readdatavalid) begin e_rd_data = avmm_readdata; finish_txn(0); end
        else if (m_age >= TMO) finish_txn(1);
      end
    end else if (m_release) begin
      if (c == 2'b00) m_release = 0;
    end else if (c != 2'b00) begin
      e_done = 0; e_terr = 0; e_cerr = 0;
      if (c == 2'b11) begin
        e_cerr = 1; e_done = 1; m_release = 1;
      end else begin
        m_busy = 1; m_age = 0; m_addr_done = 0;
        m_is_rd = (c == 2'b10);
        e_addr  = eth_ctrl_addr[15:0];
        if (m_is_rd) e_read = 1;
        else begin e_write = 1; e_wdata = eth_wr_data; end
      end
    end
  endtask

  always begin
    @(posedge clk);
    model_step();
    #1;
    check("busy", busy, m_busy);
    check("done", done, e_done);
    check("timeout_err", timeout_err, e_terr);
    check("cmd_err", cmd_err, e_cerr);
    check("eth_rd_data", eth_rd_data, e_rd_data);
    check("avmm_read", avmm_read, e_read);
    check("avmm_write", avmm_write, e_write);
    if (e_read || e_write) check("avmm_address", avmm_address, e_addr);
    if (e_write) check("avmm_writedata", avmm_writedata, e_wdata);
    if (avmm_write && !prev_wr) wr_issues++;
    if (avmm_write) wr_hi++;
    if (avmm_read) rd_hi++;
    prev_wr = avmm_write;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] c, input logic [15:0] a, input logic [31:0] d);
    eth_ctrl_addr = {14'h0, c, a};
    eth_wr_data   = d;
  endtask

  task automatic release_cmd();
    drive(2'b00, 16'h0, 32'h0);
    repeat (3) tick();
  endtask

  initial begin
    int w0, h0, r0, mode, hold;
    reset = 1'b1;
    eth_ctrl_addr = '0; eth_wr_data = '0;
    avmm_readdata = '0; avmm_readdatavalid = 1'b0; avmm_waitrequest = 1'b0;
    repeat (3) tick();
    check("reset_busy", busy, 1'b0);
    check("reset_rd_data", eth_rd_data, 32'h0);
    reset = 1'b0;
    tick();

    // Single write, no stall.
    w0 = wr_issues; h0 = wr_hi;
    drive(2'b01, 16'h0010, 32'hA5A5_0001);
    tick();
    check("t1_write_hi", avmm_write, 1'b1);
    check("t1_addr", avmm_address, 32'h10);
    check("t1_wdata", avmm_writedata, 32'hA5A5_0001);
    tick();
    check("t1_done", done, 1'b1);
    check("t1_busy_low", busy, 1'b0);
    check("t1_write_low", avmm_write, 1'b0);
    release_cmd();
    check("t1_one_write", wr_issues - w0, 1);
    check("t1_write_cycles", wr_hi - h0, 1);

    // Read with 3 stall cycles then data two cycles after the address phase.
    r0 = rd_hi;
    avmm_waitrequest = 1'b1;
    drive(2'b10, 16'h0020, 32'h0);
    tick();
    check("t2_read_hi", avmm_read, 1'b1);
    repeat (2) tick();
    tick(); avmm_waitrequest = 1'b0;
    tick();
    tick(); avmm_readdatavalid = 1'b1; avmm_readdata = 32'h1234_5678;
    tick(); avmm_readdatavalid = 1'b0;
    check("t2_read_cycles", rd_hi - r0, 4);
    check("t2_rd_data", eth_rd_data, 32'h1234_5678);
    check("t2_done", done, 1'b1);
    check("t2_no_err", timeout_err, 1'b0);
    release_cmd();

    // Held write command issues once; release and re-raise issues again.
    w0 = wr_issues;
    drive(2'b01, 16'h0030, 32'h0000_0BAD);
    repeat (50) tick();
    check("t3_held_once", wr_issues - w0, 1);
    drive(2'b00, 16'h0, 32'h0);
    repeat (2) tick();
    drive(2'b01, 16'h0030, 32'h0000_0BAD);
    repeat (4) tick();
    check("t3_rearm", wr_issues - w0, 2);
    release_cmd();

    // Read whose data never returns times out at accept+16.
    drive(2'b10, 16'h0040, 32'h0);
    repeat (16) tick();
    check("t5_busy_before", busy, 1'b1);
    check("t5_no_err_yet", timeout_err, 1'b0);
    tick();
    check("t5_timeout", timeout_err, 1'b1);
    check("t5_done", done, 1'b1);
    check("t5_read_low", avmm_read, 1'b0);
    check("t5_rd_data", eth_rd_data, 32'hDEAD_BEEF);
    release_cmd();

    // Both command bits: error, no bus activity, stale timeout flag cleared.
    drive(2'b11, 16'h0050, 32'h0);
    tick();
    check("t4_cmd_err", cmd_err, 1'b1);
    check("t4_done", done, 1'b1);
    check("t4_terr_clr", timeout_err, 1'b0);
    check("t4_no_rw", {avmm_read, avmm_write}, 2'b00);
    release_cmd();

    // Reset while waiting for read data; late readdatavalid is ignored.
    drive(2'b10, 16'h0060, 32'h0);
    tick(); tick();
    reset = 1'b1; drive(2'b00, 16'h0, 32'h0);
    tick();
    reset = 1'b0; avmm_readdatavalid = 1'b1; avmm_readdata = 32'hCAFE_F00D;
    tick(); avmm_readdatavalid = 1'b0;
    tick();
    check("t6_rd_data", eth_rd_data, 32'h0);
    check("t6_done", done, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_rw", {avmm_read, avmm_write}, 2'b00);

    // Random commands against a random slave.
    for (int t = 0; t < 300; t++) begin
      logic [1:0] c;
      logic [31:0] junk;
      c    = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 30);
      mode = $urandom_range(0, 3);
      junk = $urandom;
      for (int k = 0; k < hold; k++) begin
        eth_ctrl_addr = {junk[31:18], c, junk[15:0]};
        eth_wr_data   = $urandom;
        avmm_readdata = $urandom;
        unique case (mode)
          0: begin avmm_waitrequest = 1'b0; avmm_readdatavalid = 1'($urandom_range(0, 1)); end
          1: begin avmm_waitrequest = 1'($urandom_range(0, 1)); avmm_readdatavalid = ($urandom_range(0, 3) == 0); end
          2: begin avmm_waitrequest = 1'b1; avmm_readdatavalid = 1'b0; end
          default: begin avmm_waitrequest = ($urandom_range(0, 3) != 0); avmm_readdatavalid = ($urandom_range(0, 15) == 0); end
        endcase
        reset = ($urandom_range(0, 299) == 0);
        tick();
      end
      reset = 1'b0;
      eth_ctrl_addr[17:16] = 2'b00;
      repeat ($urandom_range(0, 3)) tick();
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_mbox_avmm_bridge.md
# eth_mbox_avmm_bridge

Converts the 32-bit Ethernet control mailbox (command/address word plus write-data word, already synchronized into the 100 MHz CSR clock domain) into single Avalon-MM transactions on the MAC/PHY CSR fabric inside the E2E Ethernet partition. It returns read data and completion status to the mailbox.
- Exactly one transaction per command arm; the next command requires the command bits to return to zero first.
- Bus timeout guards against a hung slave.

## Interface
Parameters:
- ADDR_W, 16, Avalon address width (word address, taken from mailbox bits [ADDR_W-1:0]; ADDR_W ≤ 16).
- DATA_W, 32, mailbox and Avalon data width.
- TIMEOUT_CYCLES, 1024, cycles a transaction may stay outstanding before abort (≥2).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  CSR clock; all logic on its rising edge.
- reset  in  1  synchronous active-high reset.
- eth_ctrl_addr  in  32  mailbox command: [15:0] address, [16] write request, [17] read request, [31:18] ignored.
- eth_wr_data  in  DATA_W  write payload, sampled at command accept.
- eth_rd_data  out  DATA_W  last read result; reset 0.
- busy  out  1  transaction in flight; reset 0.
- done  out  1  last accepted command completed (ok or aborted); reset 0.
- timeout_err  out  1  last command aborted by timeout; reset 0.
- cmd_err  out  1  last command had both [16] and [17] set; reset 0.
- avmm_address  out  ADDR_W  reset 0.
- avmm_read  out  1  reset 0.
- avmm_write  out  1  reset 0.
- avmm_writedata  out  DATA_W  reset 0.
- avmm_readdata  in  DATA_W  slave read data.
- avmm_readdatavalid  in  1  read-data qualifier.
- avmm_waitrequest  in  1  slave stall.

## Operation
- FSM states: IDLE, WR, RD, RD_WAIT, DISARM.
- IDLE, cmd = eth_ctrl_addr[17:16]:
  - 2'b01: latch address/data → WR; clear done/timeout_err/cmd_err.
  - 2'b10: latch address → RD; clear the same flags.
  - 2'b11: no bus activity; cmd_err=1, done=1 → DISARM.
  - 2'b00: stay in IDLE.
- WR: avmm_write=1 and address/writedata held stable until a cycle with waitrequest=0; that cycle completes the write; then done=1 → DISARM.
- RD: avmm_read=1 and address held until waitrequest=0 → RD_WAIT.
- RD_WAIT: first readdatavalid: eth_rd_data←avmm_readdata, done=1 → DISARM.
- Stray readdatavalid in any other state is ignored.
- DISARM: wait for eth_ctrl_addr[17:16]==00, then → IDLE. A command held high never issues twice.
- Timeout: counter cleared on accept, incremented each cycle in WR/RD/RD_WAIT. When it reaches TIMEOUT_CYCLES-1:
  - deassert read/write;
  - timeout_err=1 and done=1;
  - on a read, eth_rd_data←32'hDEAD_BEEF;
  - → DISARM.
  - Completion arriving on the same cycle as expiry wins: normal completion, no error.
- busy = state ∈ {WR, RD, RD_WAIT}.
- Address: mailbox bits [ADDR_W-1:0] pass through unmodified; no byte enables; no bursts.
- Reset in any state: all outputs return to reset values, FSM→IDLE, counter→0. An in-flight Avalon transaction is dropped with no completion. A command still high after reset is accepted as new.

## Timing
- Command visible at edge N (IDLE) → avmm_write/avmm_read high from cycle N+1.
- Write with waitrequest=0 at N+1: done high at N+2. Minimum write latency 2 cycles.
- Read: readdatavalid at cycle M → eth_rd_data and done updated at M+1.
- All outputs registered; no combinational path from avmm inputs to any output.
- One transaction outstanding maximum.
- done, timeout_err, cmd_err are levels that hold until the next accept.

## Structure
- Package eth_mbox_pkg:
  - command bit indices MBOX_WR_BIT=16, MBOX_RD_BIT=17;
  - state enum t_mbox_state;
  - constant MBOX_TIMEOUT_DATA=32'hDEAD_BEEF.
- Single flat module; timeout counter inline; no sub-module.

## Test plan
- Write 0x0010 data 0xA5A5_0001, waitrequest 0 → one avmm_write cycle, addr 0x0010, done at accept+2, busy low after.
- Read 0x0020, waitrequest high 3 cycles, readdatavalid 2 cycles later with 0x1234_5678 → avmm_read stable 4 cycles; eth_rd_data=0x1234_5678; done=1; no error.
- Hold write cmd for 50 cycles → exactly one avmm_write. Drop to 00, re-raise → second write issued.
- cmd=2'b11 → no read/write; cmd_err=1 and done=1 next cycle.
- Read with readdatavalid never returned, TIMEOUT_CYCLES=16 → avmm_read drops and timeout_err=1 by accept+16; eth_rd_data=0xDEAD_BEEF.
- reset asserted mid-RD_WAIT, then readdatavalid arrives → all outputs 0, rd_data unchanged at 0, FSM in IDLE.
